instr_issue_unit: RTL

- Front end that feeds the main control unit.
- Fetches 32-bit MIPS-style words from a synchronous instruction memory.
- Splits each word into opcode/fn_code/register/immediate fields and presents one instruction at a time to decode over a valid/ready handshake.
- Owns the PC, and stops on a dedicated halt word.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/instr_issue_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/issue front end and the main control unit.
// Holds instruction field positions, R-type opcode/funct values, the issue-state enum and the default halt word.
package isa_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT
  } issue_state_e;

endpackage

// File: rtl/instr_issue_unit.sv
// Fetches words from a 1-cycle synchronous imem and issues them one at a time; REQ->ISSUE takes 2 cycles.
// Backpressure: out_valid and all fields hold while out_ready is low; PC advances only on the handshake.
module instr_issue_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [5:0]        fn_code,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  issue_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        // The halt word is latched too, but HALT never presents it; PC stays on it.
        instr_d = imem_rdata;
        state_d = (imem_rdata == HALT_WORD) ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output decodes registered state only, so nothing depends combinationally on inputs.
  assign imem_en   = (state_q == ST_REQ);
  assign imem_addr = pc_q;
  assign out_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_ISSUE);
  assign halted    = (state_q == ST_HALT);
  assign pc_out    = pc_q;

  assign opcode  = instr_q[OPC_MSB:OPC_LSB];
  assign rs      = instr_q[RS_MSB:RS_LSB];
  assign rt      = instr_q[RT_MSB:RT_LSB];
  assign rd      = instr_q[RD_MSB:RD_LSB];
  assign shamt   = instr_q[SH_MSB:SH_LSB];
  assign fn_code = instr_q[FN_MSB:FN_LSB];
  assign imm     = instr_q[IMM_MSB:IMM_LSB];

endmodule
